// File: rtl/alu_muldiv_if.sv
// Handshake and result bundle between execute-stage control and the multiply/divide unit.
// MULDIV_DIV0_TRAP_EN adds the o_DivZero result flag.
interface alu_muldiv_if #(
  parameter int NBITS = 32,
  parameter int BOP   = 3
);
  logic             i_Start;
  logic [BOP-1:0]   i_Op;
  logic [NBITS-1:0] i_RegA;
  logic [NBITS-1:0] i_RegB;
  logic             i_Flush;
  logic             o_Busy;
  logic             o_Done;
  logic [NBITS-1:0] o_Hi;
  logic [NBITS-1:0] o_Lo;
`ifdef MULDIV_DIV0_TRAP_EN
  logic             o_DivZero;

  modport master (
    output i_Start, i_Op, i_RegA, i_RegB, i_Flush,
    input  o_Busy, o_Done, o_Hi, o_Lo, o_DivZero
  );
  modport slave (
    input  i_Start, i_Op, i_RegA, i_RegB, i_Flush,
    output o_Busy, o_Done, o_Hi, o_Lo, o_DivZero
  );
`else
  modport master (
    output i_Start, i_Op, i_RegA, i_RegB, i_Flush,
    input  o_Busy, o_Done, o_Hi, o_Lo
  );
  modport slave (
    input  i_Start, i_Op, i_RegA, i_RegB, i_Flush,
    output o_Busy, o_Done, o_Hi, o_Lo
  );
`endif
endinterface

// File: rtl/alu_muldiv.sv
// Iterative one-bit-per-cycle multiply/divide unit owning the HI/LO register pair.
// Optional MULDIV_DIV0_TRAP_EN: divide by zero skips the iteration and raises o_DivZero.
module alu_muldiv #(
  parameter int NBITS = 32,
  parameter int BOP   = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  alu_muldiv_if.slave bus
);

  localparam int W2 = 2 * NBITS;
  localparam int CW = $clog2(NBITS) + 1;

  localparam logic [BOP-1:0] OP_MULT  = BOP'(0);
  localparam logic [BOP-1:0] OP_MULTU = BOP'(1);
  localparam logic [BOP-1:0] OP_DIV   = BOP'(2);
  localparam logic [BOP-1:0] OP_DIVU  = BOP'(3);
  localparam logic [BOP-1:0] OP_MTHI  = BOP'(4);
  localparam logic [BOP-1:0] OP_MTLO  = BOP'(5);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [NBITS-1:0] opnd;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic [NBITS-1:0] hi_r;
  logic [NBITS-1:0] lo_r;
  logic             done_r;
`ifdef MULDIV_DIV0_TRAP_EN
  logic             div_zero_r;
`endif

  logic signed [NBITS-1:0] reg_a_s;
  logic signed [NBITS-1:0] reg_b_s;
  logic                    is_signed;
  logic                    a_neg;
  logic                    b_neg;
  logic [NBITS:0]          mul_sum;
  logic [NBITS:0]          div_shift;
  logic [NBITS:0]          div_diff;
  logic [W2-1:0]           acc_next;

  function automatic logic [NBITS-1:0] magnitude(input logic [NBITS-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [NBITS-1:0] cond_neg(input logic [NBITS-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [W2-1:0] cond_neg_wide(input logic [W2-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign reg_a_s   = bus.i_RegA;
  assign reg_b_s   = bus.i_RegB;
  assign is_signed = (bus.i_Op == OP_MULT) || (bus.i_Op == OP_DIV);
  assign a_neg     = is_signed && (reg_a_s < 0);
  assign b_neg     = is_signed && (reg_b_s < 0);

  // Iteration datapath: multiply adds into the upper half and shifts right,
  // divide shifts left and keeps the trial difference when it is non-negative.
  always_comb begin
    mul_sum   = {1'b0, acc[W2-1:NBITS]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[W2-1:NBITS-1];
    div_diff  = div_shift - {1'b0, opnd};
    acc_next  = {mul_sum, acc[NBITS-1:1]};
    if (is_div) begin
      if (div_diff[NBITS])
        acc_next = {div_shift[NBITS-1:0], acc[NBITS-2:0], 1'b0};
      else
        acc_next = {div_diff[NBITS-1:0], acc[NBITS-2:0], 1'b1};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      is_div     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      b_zero     <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      done_r     <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      div_zero_r <= 1'b0;
`endif
    end else begin
      done_r     <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      div_zero_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.i_Start && !bus.i_Flush) begin
            cnt <= '0;
            case (bus.i_Op)
              OP_MULT, OP_MULTU: begin
                opnd   <= magnitude(bus.i_RegA, a_neg);
                acc    <= {{NBITS{1'b0}}, magnitude(bus.i_RegB, b_neg)};
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= 1'b0;
                b_zero <= 1'b0;
                is_div <= 1'b0;
                state  <= CALC;
              end
              OP_DIV, OP_DIVU: begin
                opnd   <= magnitude(bus.i_RegB, b_neg);
                acc    <= {{NBITS{1'b0}}, magnitude(bus.i_RegA, a_neg)};
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                b_zero <= (bus.i_RegB == '0);
                is_div <= 1'b1;
`ifdef MULDIV_DIV0_TRAP_EN
                state  <= (bus.i_RegB == '0) ? FIX : CALC;
`else
                state  <= CALC;
`endif
              end
              OP_MTHI: begin
                hi_r   <= bus.i_RegA;
                done_r <= 1'b1;
              end
              OP_MTLO: begin
                lo_r   <= bus.i_RegA;
                done_r <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (bus.i_Flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(NBITS - 1))
              state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!bus.i_Flush) begin
            done_r <= 1'b1;
`ifdef MULDIV_DIV0_TRAP_EN
            if (is_div && b_zero)
              div_zero_r <= 1'b1;
            else
`endif
            if (is_div) begin
              lo_r <= b_zero ? '1 : cond_neg(acc[NBITS-1:0], neg_q);
              hi_r <= cond_neg(acc[W2-1:NBITS], neg_r);
            end else begin
              {hi_r, lo_r} <= cond_neg_wide(acc, neg_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Busy    = (state != IDLE);
  assign bus.o_Done    = done_r;
  assign bus.o_Hi      = hi_r;
  assign bus.o_Lo      = lo_r;
`ifdef MULDIV_DIV0_TRAP_EN
  assign bus.o_DivZero = div_zero_r;
`endif

endmodule
